// File: rtl/mul_seq_ctrl_if.sv
// Request/response bundle between the Execute stage and the multiply sequencer.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [WIDTH-1:0] srcc;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       flags;

  // Pipeline side issues requests and observes completion.
  modport master (
    output start, op, srca, srcb, srcc, flush,
    input  busy, stall, done, result, flags
  );

  // Sequencer side.
  modport slave (
    input  start, op, srca, srcb, srcc, flush,
    output busy, stall, done, result, flags
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative MUL/MLA/MLS sequencer: shift-add over RADIX_BITS multiplier bits
// per cycle, then one accumulate cycle, then a one-cycle done pulse.
module mul_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input logic           clk,
  input logic           reset,
  mul_seq_ctrl_if.slave bus
);

  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] srcc_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       flags_q;
  logic             done_q;

  logic [WIDTH-1:0] term_w;
  logic [WIDTH-1:0] final_w;

  // Partial product for this step and the accumulate/subtract result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    term_w  = mcand_q * WIDTH'(mplier_q[RADIX_BITS-1:0]);
    final_w = prod_q;
    case (op_q)
      2'b01:   final_w = srcc_q + prod_q;
      2'b10:   final_w = srcc_q - prod_q;
      default: final_w = prod_q;
    endcase
  end

  // Sequencer FSM with its datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      srcc_q   <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        // Abort discards the operation; result/flags keep their last value.
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              mcand_q  <= bus.srca;
              mplier_q <= bus.srcb;
              srcc_q   <= bus.srcc;
              op_q     <= bus.op;
              prod_q   <= '0;
              cnt_q    <= CNT_W'(N);
              state_q  <= CALC;
            end
          end
          CALC: begin
            prod_q   <= prod_q + term_w;
            mcand_q  <= mcand_q << RADIX_BITS;
            mplier_q <= mplier_q >> RADIX_BITS;
            cnt_q    <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= ACCUM;
          end
          ACCUM: begin
            result_q <= final_w;
            flags_q  <= {final_w[WIDTH-1], (final_w == '0)};
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
          default: begin
            // DONE: start is deliberately ignored here.
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy   = (state_q == CALC) || (state_q == ACCUM);
  assign bus.stall  = ((state_q == IDLE) && bus.start && !bus.flush) || bus.busy;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed scenarios plus random ops
// against an arithmetic reference model.
module tb_mul_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = 18;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH), .RADIX_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the full-width product.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
    logic [63:0] full;
    logic [31:0] p;
    full = {32'd0, a} * {32'd0, b};
    p    = full[31:0];
    case (op)
      2'b01:   return c + p;
      2'b10:   return c - p;
      default: return p;
    endcase
  endfunction

  function automatic logic [1:0] ref_flags(input logic [31:0] r);
    return {r[31], (r == 32'd0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after acceptance; counts cycles and stall until done.
  task automatic wait_done(input string tag, input logic [31:0] er);
    int cyc;
    int st;
    cyc = 1;
    st  = 1;
    while (!bus.done && cyc < 60) begin
      if (bus.stall) st++;
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, LAT);
    check({tag, "_stall"}, st, LAT);
    check({tag, "_res"}, bus.result, er);
    check({tag, "_flags"}, {30'd0, bus.flags}, {30'd0, ref_flags(er)});
    check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_stall_done"}, {31'd0, bus.stall}, 32'd0);
    tick();
    check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input bit hold);
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    bus.srcc  = c;
    bus.start = 1'b1;
    #1;
    check({tag, "_stall_req"}, {31'd0, bus.stall}, 32'd1);
    tick();
    if (!hold) begin
      bus.start = 1'b0;
      bus.op    = 2'($urandom);
      bus.srca  = $urandom;
      bus.srcb  = $urandom;
      bus.srcc  = $urandom;
    end
    wait_done(tag, ref_result(op, a, b, c));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb, rc;
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.srca  = '0;
    bus.srcb  = '0;
    bus.srcc  = '0;
    repeat (3) tick();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", {30'd0, bus.flags}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    reset = 1'b1;
    tick();

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, 32'd0, 1'b0);
    run_op("mla", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd100, 1'b0);
    run_op("mls", 2'b10, 32'd3, 32'd4, 32'd10, 1'b0);
    run_op("mul_zero", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'd5, 1'b0);

    // Flush on the 5th CALC cycle.
    run_op("mul5x5", 2'b00, 32'd5, 32'd5, 32'd0, 1'b0);
    bus.op = 2'b00; bus.srca = 32'd9; bus.srcb = 32'd9; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("fl_busy_pre", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_busy", {31'd0, bus.busy}, 32'd0);
    check("fl_done", {31'd0, bus.done}, 32'd0);
    check("fl_result", bus.result, 32'd25);
    run_op("mul9x9", 2'b00, 32'd9, 32'd9, 32'd0, 1'b0);

    // Flush in IDLE with start: not accepted.
    bus.start = 1'b1; bus.flush = 1'b1;
    #1;
    check("fl_idle_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("fl_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-CALC with start held high.
    bus.op = 2'b00; bus.srca = 32'd11; bus.srcb = 32'd13; bus.start = 1'b1;
    tick();
    repeat (3) tick();
    check("rc_busy_pre", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    tick();
    check("rc_busy", {31'd0, bus.busy}, 32'd0);
    check("rc_done", {31'd0, bus.done}, 32'd0);
    check("rc_result", bus.result, 32'd0);
    check("rc_flags", {30'd0, bus.flags}, 32'd0);
    tick();
    check("rc_busy_hold", {31'd0, bus.busy}, 32'd0);
    reset = 1'b1;
    tick();
    check("rc_accept", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    wait_done("rc_mul", 32'd143);

    // Continuous start with op 11: 19-cycle period between done pulses.
    run_op("cont1", 2'b11, 32'd2, 32'd3, 32'd0, 1'b1);
    check("cont_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("cont_idle_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    wait_done("cont2", 32'd6);
    bus.start = 1'b0;
    tick();

    // Random operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom);
      ra  = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rc  = $urandom;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, rc, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
